// File: rtl/fountain_rx_decoder.sv
// Fountain-code receiver: incremental GF(2) elimination, back-substitution and in-order
// readout of K recovered source symbols. Define FOUNTAIN_STATS_EN to build the redundant-symbol counter.
module fountain_rx_decoder #(
  parameter int K = 4,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [K-1:0]           in_mask,
  input  logic [W-1:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(K)-1:0]   out_index,
  output logic [W-1:0]           out_data,
  output logic [$clog2(K):0]     rank,
  output logic [7:0]             dup_count,
  output logic [2:0]             dbg_state
);

  localparam int IW = $clog2(K);
  localparam int RW = IW + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // valid never waits for ready; payload is held stable while valid && !ready.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_REDUCE  = 3'd2,
    S_INSERT  = 3'd3,
    S_BACKSUB = 3'd4,
    S_OUTPUT  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] step_q, step_d;
  logic [K-1:0]  work_mask_q, work_mask_d;
  logic [W-1:0]  work_data_q, work_data_d;
  logic [K-1:0]  row_valid_q, row_valid_d;
  logic [K-1:0]  row_mask_q [K];
  logic [K-1:0]  row_mask_d [K];
  logic [W-1:0]  row_data_q [K];
  logic [W-1:0]  row_data_d [K];
  logic [RW-1:0] rank_q, rank_d;
  logic [IW-1:0] ins_slot;

  function automatic logic [IW-1:0] lowest_set(input logic [K-1:0] m);
    lowest_set = '0;
    for (int b = K - 1; b >= 0; b--) begin
      if (m[b]) lowest_set = IW'(b);
    end
  endfunction

  assign ins_slot  = lowest_set(work_mask_q);
  assign rank      = rank_q;
  assign dbg_state = state_q;

`ifdef FOUNTAIN_STATS_EN
  logic [7:0] dup_q, dup_d;
  assign dup_count = dup_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dup_q <= '0;
    else     dup_q <= dup_d;
  end
`else
  assign dup_count = '0;
`endif

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    work_mask_d = work_mask_q;
    work_data_d = work_data_q;
    row_valid_d = row_valid_q;
    row_mask_d  = row_mask_q;
    row_data_d  = row_data_q;
    rank_d      = rank_q;
`ifdef FOUNTAIN_STATS_EN
    dup_d       = dup_q;
`endif
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_index   = '0;
    out_data    = '0;

    case (state_q)
      S_IDLE: state_d = S_COLLECT;

      S_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_mask_d = in_mask;
          work_data_d = in_data;
          step_d      = '0;
          state_d     = S_REDUCE;
        end
      end

      // Row at slot i owns pivot i, so eliminating pivots in ascending order is complete.
      S_REDUCE: begin
        if (work_mask_q[step_q] && row_valid_q[step_q]) begin
          work_mask_d = work_mask_q ^ row_mask_q[step_q];
          work_data_d = work_data_q ^ row_data_q[step_q];
        end
        if (step_q == IW'(K - 1)) state_d = S_INSERT;
        else                      step_d  = step_q + IW'(1);
      end

      S_INSERT: begin
        if (work_mask_q == '0) begin
`ifdef FOUNTAIN_STATS_EN
          if (dup_q != 8'hFF) dup_d = dup_q + 8'd1;
`endif
          state_d = S_COLLECT;
        end else begin
          row_valid_d[ins_slot] = 1'b1;
          row_mask_d[ins_slot]  = work_mask_q;
          row_data_d[ins_slot]  = work_data_q;
          rank_d                = rank_q + RW'(1);
          if (rank_q == RW'(K - 1)) begin
            step_d  = IW'(K - 1);
            state_d = S_BACKSUB;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end

      // Pivot row j is already clean above j, since higher pivots were processed first.
      S_BACKSUB: begin
        for (int i = 0; i < K; i++) begin
          if (i < int'(step_q) && row_mask_q[i][step_q]) begin
            row_mask_d[i] = row_mask_q[i] ^ row_mask_q[step_q];
            row_data_d[i] = row_data_q[i] ^ row_data_q[step_q];
          end
        end
        if (step_q == IW'(1)) begin
          step_d  = '0;
          state_d = S_OUTPUT;
        end else begin
          step_d = step_q - IW'(1);
        end
      end

      S_OUTPUT: begin
        out_valid = 1'b1;
        out_index = step_q;
        out_data  = row_data_q[step_q];
        if (out_ready) begin
          if (step_q == IW'(K - 1)) begin
            row_valid_d = '0;
            for (int i = 0; i < K; i++) begin
              row_mask_d[i] = '0;
              row_data_d[i] = '0;
            end
            rank_d  = '0;
            step_d  = '0;
            state_d = S_COLLECT;
          end else begin
            step_d = step_q + IW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      work_mask_q <= '0;
      work_data_q <= '0;
      row_valid_q <= '0;
      rank_q      <= '0;
      for (int i = 0; i < K; i++) begin
        row_mask_q[i] <= '0;
        row_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      work_mask_q <= work_mask_d;
      work_data_q <= work_data_d;
      row_valid_q <= row_valid_d;
      rank_q      <= rank_d;
      for (int i = 0; i < K; i++) begin
        row_mask_q[i] <= row_mask_d[i];
        row_data_q[i] <= row_data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fountain_rx_decoder.sv
// Directed bench for fountain_rx_decoder: decode, redundancy, reduction, backpressure,
// zero mask and mid-block reset, with hand-computed expectations.
module tb_fountain_rx_decoder;
  localparam int K = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_mask;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_index;
  logic [W-1:0] out_data;
  logic [2:0]   rank;
  logic [7:0]   dup_count;
  logic [2:0]   dbg_state;

  int n_cmp   = 0;
  int n_bad   = 0;
  int exp_dup = 0;

  always #5 clk = ~clk;

  fountain_rx_decoder #(.K(K), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_data  (out_data),
    .rank      (rank),
    .dup_count (dup_count),
    .dbg_state (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int t = 0; t < 30 && in_ready !== 1'b1; t++) tick();
    check("wait_in_ready", in_ready, 1);
  endtask

  // Accept one symbol, keep junk on the bus while busy, then check rank/dup/in_ready.
  task automatic send_sym(input logic [K-1:0] m, input logic [W-1:0] d,
                          input int exp_rank, input bit full, input bit redundant);
    wait_ready();
    in_valid = 1'b1;
    in_mask  = m;
    in_data  = d;
    tick();
    in_mask = '1;
    in_data = '1;
    for (int c = 1; c <= K + 1; c++) begin
      check("busy_in_ready", in_ready, 0);
      if (c < K + 1) tick();
    end
    in_valid = 1'b0;
    tick();
`ifdef FOUNTAIN_STATS_EN
    if (redundant) exp_dup++;
`endif
    check("rank", rank, exp_rank);
    check("ready_after_k_plus_2", in_ready, full ? 0 : 1);
    check("dup_count", dup_count, exp_dup);
  endtask

  task automatic recv_block(input logic [K*W-1:0] exp, input int stall_at);
    logic [W-1:0] e;
    for (int t = 0; t < 20 && out_valid !== 1'b1; t++) tick();
    check("out_valid_wait", out_valid, 1);
    for (int n = 0; n < K; n++) begin
      e = exp[n*W +: W];
      if (n == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          check("stall_valid", out_valid, 1);
          check("stall_index", out_index, n);
          check("stall_data", out_data, e);
          tick();
        end
        out_ready = 1'b1;
      end
      check("out_valid", out_valid, 1);
      check("out_index", out_index, n);
      check("out_data", out_data, e);
      tick();
    end
    check("done_in_ready", in_ready, 1);
    check("done_out_valid", out_valid, 0);
    check("done_rank", rank, 0);
  endtask

  task automatic basic_block(input int stall_at);
    send_sym(4'b0011, 8'h33, 1, 1'b0, 1'b0);
    send_sym(4'b0110, 8'h66, 2, 1'b0, 1'b0);
    send_sym(4'b1100, 8'hCC, 3, 1'b0, 1'b0);
    send_sym(4'b1000, 8'h88, 4, 1'b1, 1'b0);
    recv_block(32'h88442211, stall_at);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mask   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_index", out_index, 0);
    check("reset_out_data", out_data, 0);
    check("reset_rank", rank, 0);
    check("reset_dup", dup_count, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;
    check("release_in_ready", in_ready, 0);
    tick();
    check("collect_in_ready", in_ready, 1);

    // Basic decode.
    basic_block(-1);

    // Redundant symbol.
    send_sym(4'b0011, 8'h33, 1, 1'b0, 1'b0);
    send_sym(4'b0011, 8'h33, 1, 1'b0, 1'b1);
    send_sym(4'b0110, 8'h66, 2, 1'b0, 1'b0);
    send_sym(4'b1100, 8'hCC, 3, 1'b0, 1'b0);
    send_sym(4'b1000, 8'h88, 4, 1'b1, 1'b0);
    recv_block(32'h88442211, -1);

    // Reduction path with output backpressure at index 1.
    send_sym(4'b0011, 8'h33, 1, 1'b0, 1'b0);
    send_sym(4'b0110, 8'h66, 2, 1'b0, 1'b0);
    send_sym(4'b0111, 8'h77, 3, 1'b0, 1'b0);
    send_sym(4'b1000, 8'h88, 4, 1'b1, 1'b0);
    recv_block(32'h88442211, 1);

    // Zero mask.
    send_sym(4'b0000, 8'h5A, 0, 1'b0, 1'b1);

    // Mid-operation reset during REDUCE of the third symbol.
    send_sym(4'b0011, 8'h33, 1, 1'b0, 1'b0);
    send_sym(4'b0110, 8'h66, 2, 1'b0, 1'b0);
    wait_ready();
    in_valid = 1'b1;
    in_mask  = 4'b1100;
    in_data  = 8'hCC;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_busy", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    exp_dup = 0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_index", out_index, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_rank", rank, 0);
    check("midrst_dup", dup_count, 0);
    tick();
    rst = 1'b0;
    tick();
    basic_block(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fountain_rx_decoder.md
Name: fountain_rx_decoder

Overview:
- Receive-side counterpart of the fountain encoder in tt_um_fountaincoder_top_V2.
- Accepts a stream of encoded symbols. Each symbol is a K-bit degree mask plus a W-bit XOR of the selected source bytes.
- Recovers the K source bytes by incremental GF(2) elimination followed by back-substitution.
- Emits the recovered bytes in index order over a valid/ready port. Used as the loopback and decode end in the chip-level testbench and in the board harness.

Parameters:
- K, 4, number of source symbols per block (2..8).
- W, 8, symbol data width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  encoded symbol present.
- in_ready  out  1  decoder accepts a symbol this cycle.
- in_mask  in  K  degree mask; bit i set means source i is included in the XOR.
- in_data  in  W  XOR of the selected source symbols.
- out_valid  out  1  recovered symbol present.
- out_ready  in  1  downstream accepts the recovered symbol.
- out_index  out  clog2(K)  index of the recovered symbol.
- out_data  out  W  recovered source symbol.
- rank  out  clog2(K)+1  number of independent rows stored.
- dup_count  out  8  redundant-symbol counter (see Optional Feature).

Behaviour:
- Interface: already decided, one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset values:
  - in_ready=0, out_valid=0, out_index=0, out_data=0, rank=0, dup_count=0.
  - All row_valid bits cleared; FSM enters COLLECT on the first clock after rst deasserts.
- Storage: K rows, each {valid, mask[K], data[W]}. A row stored at slot p has its lowest set mask bit at position p.
- FSM states: COLLECT, REDUCE, INSERT, BACKSUB, OUTPUT.
- COLLECT:
  - in_ready=1.
  - On in_valid&&in_ready, latch the work register {mask, data} and go to REDUCE with step i=0.
- REDUCE:
  - Runs K cycles, i=0..K-1.
  - In each cycle, if work.mask[i] and row[i].valid, then work ^= row[i].
  - After step K-1, go to INSERT.
- INSERT (1 cycle):
  - If work.mask==0: discard the symbol, increment dup_count (saturating at 255), return to COLLECT.
  - Otherwise: store work at slot p = lowest set bit of work.mask, set row[p].valid, rank++.
  - If rank reaches K, go to BACKSUB with j=K-1; otherwise return to COLLECT.
- Throughput: accept to next in_ready=1 is K+2 cycles.
- BACKSUB:
  - Runs K-1 cycles, j=K-1 down to 1.
  - In each cycle, for every i<j in parallel: if row[i].mask[j], then row[i] ^= row[j].
  - Then go to OUTPUT with index 0.
- OUTPUT:
  - out_valid=1, out_index=n, out_data=row[n].data.
  - Advance n on out_ready.
  - out_data and out_index are held stable while out_valid&&!out_ready.
  - After index K-1 is accepted: clear all rows, set rank=0, return to COLLECT.
  - dup_count persists across blocks; only rst clears it.
- in_mask==0: treated as redundant; it passes through REDUCE unchanged, then INSERT discards it and counts it.
- in_valid while not in COLLECT is ignored, because in_ready=0.
- rst asserted in any state: immediate clear to reset values; any partial block is lost.

Optional Feature:
- Macro: FOUNTAIN_STATS_EN.
- Defined: dup_count is implemented as an 8-bit saturating counter of discarded symbols.
- Undefined: dup_count is tied to 0 and the counter logic is removed. Decode behaviour is otherwise identical.

Test Plan:
- Basic decode. Sources 0x11,0x22,0x44,0x88. Send (0011,0x33), (0110,0x66), (1100,0xCC), (1000,0x88), each with in_valid held high.
  - Expect rank stepping 1,2,3,4.
  - Expect outputs (0,0x11), (1,0x22), (2,0x44), (3,0x88).
  - Expect in_ready low K+2=6 cycles after each accept.
- Redundant symbol. Send (0011,0x33) twice.
  - Expect rank=1 after both.
  - Expect dup_count=1 with the macro, 0 without.
  - Finish with (0110,0x66), (1100,0xCC), (1000,0x88) and expect the same outputs as the basic decode.
- Reduction path. Send (0011,0x33), then (0110,0x66), then (0111,0x77).
  - The third symbol reduces to (0100,0x44) and is stored at slot 2; rank=3.
  - Add (1000,0x88) and expect decode of 0x11,0x22,0x44,0x88.
- Output backpressure. Hold out_ready=0 for 5 cycles during OUTPUT at index 1.
  - Expect out_valid=1, out_index=1, out_data=0x22 stable throughout.
  - Release and expect indices 2 and 3 to follow, then in_ready=1 on return to COLLECT.
- Zero mask. Send (0000,0x5A).
  - Expect it discarded, rank unchanged, dup_count incremented with the macro.
- Mid-operation reset. Assert rst during REDUCE of the third symbol.
  - Expect all outputs at reset values the same cycle.
  - After release, a fresh full block must decode correctly.
